// File: rtl/run_pattern_gen_pkg.sv
// Shared state encoding and run-length legality helper for run_pattern_gen.
package run_pattern_gen_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ERR  = 3'd1,
    PRE  = 3'd2,
    RUN  = 3'd3,
    TERM = 3'd4,
    DONE = 3'd5
  } state_e;

  function automatic logic len_legal(
    input int unsigned len,
    input int unsigned max_run
  );
    return (len != 0) && (len <= max_run);
  endfunction

endpackage

// File: rtl/run_pattern_gen_counter.sv
// Loadable down counter; at_one marks the last RUN cycle so it never wraps.
module run_down_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         dec_i,
  input  logic [W-1:0] load_val_i,
  output logic [W-1:0] value_o,
  output logic         at_one_o
);

  logic [W-1:0] value_q;
  logic [W-1:0] value_d;

  always_comb begin
    value_d = value_q;
    if (load_i) begin
      value_d = load_val_i;
    end else if (dec_i) begin
      value_d = value_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value_o  = value_q;
  assign at_one_o = (value_q == W'(1));

endmodule

// File: rtl/run_pattern_gen.sv
// Framed run-of-ones serial transmitter (0, N ones, 0, then IDLE_LVL).
// Optional RUN_PATTERN_GEN_REPEAT_EN adds repeat_i for back-to-back frames.
module run_pattern_gen #(
  parameter int unsigned MAX_RUN  = 15,
  parameter int unsigned CNT_W    = $clog2(MAX_RUN + 1),
  parameter logic        IDLE_LVL = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] run_len,
`ifdef RUN_PATTERN_GEN_REPEAT_EN
  input  logic             repeat_i,
`endif
  output logic             outp,
  output logic             busy,
  output logic             done,
  output logic             err
);

  import run_pattern_gen_pkg::*;

  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] load_val;
  logic             load;
  logic             dec;
  logic             at_one;
  logic             legal;
  logic             rpt;
  logic             accept;
  logic             outp_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;

`ifdef RUN_PATTERN_GEN_REPEAT_EN
  assign rpt = repeat_i;
`else
  assign rpt = 1'b0;
`endif

  assign legal  = len_legal(32'(run_len), MAX_RUN);
  assign accept = (state_q == IDLE) && start && legal;

  // Repeat reloads from the latched length, not the live input.
  assign load     = accept || ((state_q == DONE) && rpt);
  assign load_val = (state_q == DONE) ? len_q : run_len;
  assign dec      = (state_q == RUN) && (cnt != '0);

  run_down_counter #(
    .W (CNT_W)
  ) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (load),
    .dec_i      (dec),
    .load_val_i (load_val),
    .value_o    (cnt),
    .at_one_o   (at_one)
  );

  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = legal ? PRE : ERR;
        end else begin
          state_d = IDLE;
        end
      end
      ERR:     state_d = IDLE;
      PRE:     state_d = RUN;
      RUN:     state_d = at_one ? TERM : RUN;
      TERM:    state_d = DONE;
      DONE:    state_d = rpt ? PRE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state, so they track state_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      outp_q  <= IDLE_LVL;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        len_q <= run_len;
      end
      outp_q <= IDLE_LVL;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (1'b1)
        (state_d == ERR): begin
          err_q <= 1'b1;
        end
        (state_d == PRE): begin
          outp_q <= 1'b0;
          busy_q <= 1'b1;
        end
        (state_d == RUN): begin
          outp_q <= 1'b1;
          busy_q <= 1'b1;
        end
        (state_d == TERM): begin
          outp_q <= 1'b0;
          busy_q <= 1'b1;
        end
        (state_d == DONE): begin
          busy_q <= 1'b1;
          done_q <= 1'b1;
        end
        default: begin
          outp_q <= IDLE_LVL;
        end
      endcase
    end
  end

  assign outp = outp_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_run_pattern_gen.sv
// Bench for run_pattern_gen: frame-queue model plus directed literal checks.
module tb_run_pattern_gen;

  localparam int unsigned MAX_RUN  = 15;
  localparam int unsigned CNT_W    = 5;
  localparam bit          IDLE_LVL = 1'b1;

  localparam logic [3:0] IDLE_V = {IDLE_LVL, 3'b000};
  localparam logic [3:0] ERR_V  = {IDLE_LVL, 3'b001};
  localparam logic [3:0] DONE_V = {IDLE_LVL, 3'b110};

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] run_len = '0;
  logic             rpt = 1'b0;
  logic             outp;
  logic             busy;
  logic             done;
  logic             err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  run_pattern_gen #(
    .MAX_RUN  (MAX_RUN),
    .CNT_W    (CNT_W),
    .IDLE_LVL (IDLE_LVL)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .run_len  (run_len),
`ifdef RUN_PATTERN_GEN_REPEAT_EN
    .repeat_i (rpt),
`endif
    .outp     (outp),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  // Model: a queue of per-cycle {outp,busy,done,err} for the frame in flight.
  logic [3:0] q[$];
  logic [3:0] exp_v = IDLE_V;
  int         last_len = 0;

  task automatic push_frame(input int n);
    q.push_back(4'b0100);
    for (int i = 0; i < n; i++) q.push_back(4'b1100);
    q.push_back(4'b0100);
    q.push_back(DONE_V);
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      exp_v = IDLE_V;
    end else begin
      if (q.size() == 0) begin
        if (exp_v == DONE_V && rpt) begin
          push_frame(last_len);
        end else if (exp_v == IDLE_V && start) begin
          if (int'(run_len) >= 1 && int'(run_len) <= int'(MAX_RUN)) begin
            last_len = int'(run_len);
            push_frame(last_len);
          end else begin
            q.push_back(ERR_V);
          end
        end
      end
      exp_v = (q.size() != 0) ? q.pop_front() : IDLE_V;
    end
  end

  always @(negedge clk) begin
    n_tests++;
    if ({outp, busy, done, err} !== exp_v) begin
      n_fail++;
      $display("FAIL model t=%0t: {outp,busy,done,err} got %b expected %b",
               $time, {outp, busy, done, err}, exp_v);
    end
  end

  task automatic check(input string name, input int act, input int expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic start_frame(input int n);
    @(posedge clk);
    #1;
    start   = 1'b1;
    run_len = CNT_W'(n);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic count_to_done(output int ones, output int ok);
    ones = 0;
    ok   = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy && outp && !done) ones++;
      if (done) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic frame_check(input string name, input int n);
    int ones;
    int dn;
    int cyc;
    ones = 0;
    dn   = 0;
    cyc  = 0;
    start_frame(n);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) break;
      cyc++;
      if (outp && !done) ones++;
      if (done) dn++;
    end
    check({name, "_ones"}, ones, n);
    check({name, "_done"}, dn, 1);
    check({name, "_busy_cycles"}, cyc, n + 3);
  endtask

  initial begin
    int seq;
    int bc;
    int dc;
    int ones;
    int ok;
    int nd;
    int dt[8];

    #1 rst = 1'b1;
    #11;
    check("reset_outp", int'(outp), int'(IDLE_LVL));
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_err", int'(err), 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // N=4: outp 0,1,1,1,1,0,IDLE_LVL with done on the last cycle
    start_frame(4);
    seq = 0;
    bc  = 0;
    dc  = 0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      seq = (seq << 1) | int'(outp);
      bc += int'(busy);
      if (done) dc = (i == 6) ? dc + 1 : dc + 100;
    end
    check("n4_seq", seq, 7'b0111101);
    check("n4_busy", bc, 7);
    check("n4_done", dc, 1);
    @(negedge clk);
    check("n4_idle_busy", int'(busy), 0);

    frame_check("n1", 1);
    frame_check("n15", 15);

    // Illegal lengths
    start_frame(0);
    @(negedge clk);
    check("len0_err", int'(err), 1);
    check("len0_busy", int'(busy), 0);
    check("len0_outp", int'(outp), int'(IDLE_LVL));
    @(negedge clk);
    check("len0_err_drop", int'(err), 0);
    start_frame(16);
    @(negedge clk);
    check("len16_err", int'(err), 1);
    check("len16_busy", int'(busy), 0);
    @(negedge clk);
    check("len16_err_drop", int'(err), 0);
    frame_check("after_err", 2);

    // Reset after two ones of an N=5 frame
    start_frame(5);
    repeat (3) @(negedge clk);
    check("pre_rst_outp", int'(outp), 1);
    #1 rst = 1'b1;
    #1;
    check("rst_mid_outp", int'(outp), int'(IDLE_LVL));
    check("rst_mid_busy", int'(busy), 0);
    check("rst_mid_done", int'(done), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    dc = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      dc += int'(done);
    end
    check("rst_no_done", dc, 0);

    // Start held high, N=3: frames every 7 cycles
    @(posedge clk);
    #1;
    start   = 1'b1;
    run_len = CNT_W'(3);
    nd = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done && nd < 8) begin
        dt[nd] = i;
        nd++;
      end
    end
    check("held_ndone", int'(nd >= 3), 1);
    check("held_gap1", dt[1] - dt[0], 7);
    check("held_gap2", dt[2] - dt[1], 7);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    @(negedge clk);
    #1 run_len = CNT_W'(9);
    count_to_done(ones, ok);
    check("held_cur_ones", ones, 3);
    check("held_cur_ok", ok, 1);
    count_to_done(ones, ok);
    check("held_next_ones", ones, 9);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    check("held_stop_busy", int'(busy), 0);

`ifdef RUN_PATTERN_GEN_REPEAT_EN
    rpt = 1'b1;
    start_frame(2);
    seq = 0;
    dc  = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      seq = (seq << 1) | int'(outp);
      dc += int'(done);
    end
    check("rpt_seq", seq, 10'b0110101101);
    check("rpt_done", dc, 2);
    #1 rpt = 1'b0;
    @(negedge clk);
    check("rpt_stop_busy", int'(busy), 0);
    repeat (3) @(negedge clk);
`endif

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
